// File: rtl/bitserial_pkg.sv
// Shared types and sizing helpers for the bit-serial operand sequencer.
// Default widths and the FSM state encoding live here.
package bitserial_pkg;

  localparam int DEF_A       = 4;
  localparam int DEF_B       = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int PROD_WIDTH  = DEF_A + DEF_B;

  function automatic int cnt_width(int b, int t);
    int m;
    m = (b > t) ? b : t;
    return $clog2(m + 1);
  endfunction

  localparam int CNT_WIDTH = cnt_width(DEF_B, DEF_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT_DONE,
    ST_RESULT
  } state_e;

endpackage

// File: rtl/bitserial_operand_sequencer_skid.sv
// One-entry pending slot for {multiplicand, multiplier}.
// An empty slot passes a pair straight through when it is consumed at once.
module operand_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // Bypass when empty, hold one pair otherwise.
  always_comb begin
    in_ready  = ~full_q;
    out_valid = full_q | in_valid;
    out_data  = full_q ? data_q : in_data;
    full_d    = full_q;
    data_d    = data_q;
    if (full_q) begin
      if (out_ready) full_d = 1'b0;
    end else if (in_valid && !out_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Slot storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/bitserial_operand_sequencer.sv
// Feeds operands bit-serially to the sequential multiplier
// and returns its product over a valid/ready handshake.
module bitserial_operand_sequencer
  import bitserial_pkg::*;
#(
  parameter int MULTIPLICAND_WIDTH = DEF_A,
  parameter int MULTIPLIER_WIDTH   = DEF_B,
  parameter int DONE_TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MULTIPLICAND_WIDTH-1:0] in_multiplicand,
  input  logic [MULTIPLIER_WIDTH-1:0]   in_multiplier,
  output logic                          mult_start,
  output logic [MULTIPLICAND_WIDTH-1:0] mult_multiplicand,
  output logic [MULTIPLIER_WIDTH-1:0]   mult_multiplier,
  output logic                          mult_serial_bit,
  input  logic                          mult_done,
  input  logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] mult_product,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] out_product,
  output logic                          err_timeout
);

  localparam int AW = MULTIPLICAND_WIDTH;
  localparam int BW = MULTIPLIER_WIDTH;
  localparam int PW = AW + BW;
  localparam int CW = cnt_width(BW, DONE_TIMEOUT);

  state_e          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   t_q, t_d;
  logic [AW-1:0]   a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            ov_q, ov_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            done_rise;
  logic            take;
  logic            slot_valid;
  logic [PW-1:0]   slot_data;
  logic [BW-1:0]   b_shifted;

  operand_skid_slot #(.W(PW)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_multiplicand, in_multiplier}),
    .out_valid (slot_valid),
    .out_ready (take),
    .out_data  (slot_data)
  );

  assign done_rise         = mult_done & ~done_q;
  assign b_shifted         = b_q >> k_q;
  assign mult_start        = (state_q == ST_SHIFT) && (k_q == '0) && !rst;
  assign mult_serial_bit   = (state_q == ST_SHIFT) & b_shifted[0];
  assign mult_multiplicand = a_q;
  assign mult_multiplier   = b_q;
  assign out_valid         = ov_q;
  assign out_product       = prod_q;
  assign err_timeout       = err_q;

  // Next-state: launch, shift, wait for done, present result.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    ov_d    = ov_q;
    err_d   = err_q;
    done_d  = mult_done;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (slot_valid) begin
          take    = 1'b1;
          a_d     = slot_data[PW-1:BW];
          b_d     = slot_data[BW-1:0];
          k_d     = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (k_q == CW'(BW - 1)) begin
          t_d     = '0;
          state_d = ST_WAIT_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (done_rise) begin
          prod_d  = mult_product;
          ov_d    = 1'b1;
          state_d = ST_RESULT;
        end else if (t_q == CW'(DONE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          ov_d = 1'b0;
          if (slot_valid) begin
            take    = 1'b1;
            a_d     = slot_data[PW-1:BW];
            b_d     = slot_data[BW-1:0];
            k_d     = '0;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bitserial_operand_sequencer.sv
// Bench for the bit-serial operand sequencer: directed corner cases,
// a vector table and randomized traffic against a behavioural multiplier.
module tb_bitserial_operand_sequencer;

  localparam int A  = 4;
  localparam int B  = 4;
  localparam int PW = A + B;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [A-1:0]  in_multiplicand;
  logic [B-1:0]  in_multiplier;
  logic          mult_start;
  logic [A-1:0]  mult_multiplicand;
  logic [B-1:0]  mult_multiplier;
  logic          mult_serial_bit;
  logic          mult_done;
  logic [PW-1:0] mult_product;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_product;
  logic          err_timeout;

  always #5 clk = ~clk;

  bitserial_operand_sequencer #(
    .MULTIPLICAND_WIDTH (A),
    .MULTIPLIER_WIDTH   (B),
    .DONE_TIMEOUT       (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_multiplicand   (in_multiplicand),
    .in_multiplier     (in_multiplier),
    .mult_start        (mult_start),
    .mult_multiplicand (mult_multiplicand),
    .mult_multiplier   (mult_multiplier),
    .mult_serial_bit   (mult_serial_bit),
    .mult_done         (mult_done),
    .mult_product      (mult_product),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_product       (out_product),
    .err_timeout       (err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] sb_q[$];

  bit           auto_mult;
  int           m_n;
  int           wait_ctr;
  logic [A-1:0] m_a;
  logic [B-1:0] m_b;

  typedef struct {
    logic [A-1:0]  a;
    logic [B-1:0]  b;
    logic [PW-1:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard the handshakes about to happen, advance,
  // then let the multiplier model react to what it sees.
  task automatic step();
    if (!rst && in_valid && in_ready)
      sb_q.push_back(PW'(in_multiplicand) * PW'(in_multiplier));
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("sb_unexpected_result", 1, 0);
      else check("sb_product", out_product, sb_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (auto_mult) begin
      mult_done = 1'b0;
      if (wait_ctr > 0) begin
        wait_ctr--;
        if (wait_ctr == 0) begin
          mult_done    = 1'b1;
          mult_product = PW'(m_a) * PW'(m_b);
        end
      end
      if (mult_start) begin
        m_a = mult_multiplicand;
        m_b = B'(mult_serial_bit);
        m_n = 1;
      end else if (m_n > 0 && m_n < B) begin
        m_b = m_b | (B'(mult_serial_bit) << m_n);
        m_n++;
        if (m_n == B) wait_ctr = 1 + $urandom_range(0, 4);
      end
    end
  endtask

  task automatic wait_out(int max);
    for (int i = 0; i < max && !out_valid; i++) step();
    check("wait_out_valid", out_valid, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'h0, 4'h0, 8'h00};
    vecs[1] = '{4'hF, 4'h1, 8'h0F};
    vecs[2] = '{4'h1, 4'hF, 8'h0F};
    vecs[3] = '{4'h8, 4'h8, 8'h40};
    vecs[4] = '{4'hF, 4'hF, 8'hE1};
    vecs[5] = '{4'hA, 4'h5, 8'h32};
    vecs[6] = '{4'h7, 4'h9, 8'h3F};

    rst = 1'b1; in_valid = 1'b0; in_multiplicand = '0; in_multiplier = '0;
    mult_done = 1'b0; mult_product = '0; out_ready = 1'b0;
    auto_mult = 1'b1; m_n = 0; wait_ctr = 0; m_a = '0; m_b = '0;
    #1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_start", mult_start, 0);
    check("rst_err", err_timeout, 0);
    check("rst_serial", mult_serial_bit, 0);
    check("rst_mcand", mult_multiplicand, 0);
    check("rst_mplier", mult_multiplier, 0);
    check("rst_product", out_product, 0);

    // Single op 2*6: start one cycle after transfer, bits 0,1,1,0.
    in_valid = 1; in_multiplicand = 4'h2; in_multiplier = 4'h6;
    step();
    in_valid = 0;
    check("single_start", mult_start, 1);
    check("single_bit0", mult_serial_bit, 0);
    check("single_mplier_held", mult_multiplier, 4'h6);
    step();
    check("single_start_once", mult_start, 0);
    check("single_bit1", mult_serial_bit, 1);
    step();
    check("single_bit2", mult_serial_bit, 1);
    step();
    check("single_bit3", mult_serial_bit, 0);
    step();
    check("single_wait_bit", mult_serial_bit, 0);
    check("single_mcand_held", mult_multiplicand, 4'h2);
    wait_out(20);
    check("single_product", out_product, 8'h0C);
    repeat (3) step();
    check("single_held_valid", out_valid, 1);
    check("single_held_product", out_product, 8'h0C);
    out_ready = 1;
    step();
    out_ready = 0;
    check("single_valid_drop", out_valid, 0);

    // Back-to-back F*F then 3*5.
    out_ready = 1;
    in_valid = 1; in_multiplicand = 4'hF; in_multiplier = 4'hF;
    step();
    in_multiplicand = 4'h3; in_multiplier = 4'h5;
    check("b2b_accept_second", in_ready, 1);
    step();
    in_valid = 0;
    check("b2b_slot_full", in_ready, 0);
    wait_out(30);
    check("b2b_first", out_product, 8'hE1);
    check("b2b_still_full", in_ready, 0);
    step();
    check("b2b_zero_bubble_start", mult_start, 1);
    check("b2b_slot_freed", in_ready, 1);
    check("b2b_valid_drop", out_valid, 0);
    wait_out(30);
    check("b2b_second", out_product, 8'h0F);
    step();
    out_ready = 0;

    // Downstream stall with a queued op and a refused third input.
    in_valid = 1; in_multiplicand = 4'h2; in_multiplier = 4'h6;
    step();
    in_multiplicand = 4'h3; in_multiplier = 4'h3;
    step();
    in_multiplicand = 4'h7; in_multiplier = 4'h7;
    check("stall_refuse", in_ready, 0);
    wait_out(30);
    check("stall_product", out_product, 8'h0C);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_hold_product", out_product, 8'h0C);
      check("stall_refuse_hold", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    step();
    check("stall_launch", mult_start, 1);
    wait_out(30);
    check("stall_second", out_product, 8'h09);
    step();
    out_ready = 0;

    // Level done held across two ops counts once per op.
    auto_mult = 0; mult_done = 0; out_ready = 1;
    in_valid = 1; in_multiplicand = 4'h2; in_multiplier = 4'h3;
    step();
    in_multiplicand = 4'h4; in_multiplier = 4'h5;
    step();
    in_valid = 0;
    repeat (3) step();
    mult_done = 1; mult_product = 8'h06;
    step();
    check("level_op1_valid", out_valid, 1);
    check("level_op1_product", out_product, 8'h06);
    step();
    check("level_op2_start", mult_start, 1);
    check("level_op1_once", out_valid, 0);
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("level_no_recount", out_valid, 0);
    end
    mult_done = 0;
    step();
    mult_done = 1; mult_product = 8'h14;
    step();
    check("level_op2_valid", out_valid, 1);
    check("level_op2_product", out_product, 8'h14);
    step();
    mult_done = 0;

    // Timeout: no done for 16 WAIT_DONE cycles, pending pair still runs.
    in_valid = 1; in_multiplicand = 4'h1; in_multiplier = 4'h1;
    step();
    in_multiplicand = 4'h2; in_multiplier = 4'h2;
    step();
    in_valid = 0;
    repeat (3) step();
    for (int i = 0; i < 16; i++) begin
      check("to_err_early", err_timeout, 0);
      check("to_no_result", out_valid, 0);
      step();
    end
    check("to_err_set", err_timeout, 1);
    check("to_no_result_after", out_valid, 0);
    check("to_idle_no_start", mult_start, 0);
    void'(sb_q.pop_front());
    auto_mult = 1; m_n = 0; wait_ctr = 0;
    step();
    check("to_pending_launch", mult_start, 1);
    wait_out(30);
    check("to_pending_product", out_product, 8'h04);
    step();
    check("to_err_sticky", err_timeout, 1);
    out_ready = 0;

    // Reset mid-SHIFT at k=2 with a pair pending.
    in_valid = 1; in_multiplicand = 4'h2; in_multiplier = 4'h6;
    step();
    in_multiplicand = 4'h3; in_multiplier = 4'h3;
    step();
    in_valid = 0;
    step();
    check("rst_mid_k2_bit", mult_serial_bit, 1);
    rst = 1;
    check("rst_cycle_no_start", mult_start, 0);
    step();
    rst = 0; sb_q.delete(); m_n = 0; wait_ctr = 0; mult_done = 0;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_start", mult_start, 0);
    check("rst_mid_serial", mult_serial_bit, 0);
    check("rst_mid_mcand", mult_multiplicand, 0);
    check("rst_mid_mplier", mult_multiplier, 0);
    check("rst_mid_err", err_timeout, 0);
    check("rst_mid_product", out_product, 0);
    step();
    check("rst_pending_dropped", mult_start, 0);
    out_ready = 1;
    in_valid = 1; in_multiplicand = 4'h2; in_multiplier = 4'h6;
    step();
    in_valid = 0;
    check("rst_fresh_start", mult_start, 1);
    wait_out(30);
    check("rst_fresh_product", out_product, 8'h0C);
    step();
    out_ready = 0;

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1;
      in_multiplicand = vecs[i].a;
      in_multiplier = vecs[i].b;
      step();
      in_valid = 0;
      wait_out(40);
      check("vec_product", out_product, vecs[i].exp);
      out_ready = 1;
      step();
      out_ready = 0;
    end

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_multiplicand = A'($urandom);
      in_multiplier = B'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 300 && sb_q.size() > 0; i++) step();
    check("rand_drain", sb_q.size(), 0);
    check("rand_no_timeout", err_timeout, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
